adder_result_stage: RTL and testbench
=====================================

ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 SHALL have parameter N, default 32: operand/sum width from the upstream 32-bit ripple adder.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: upstream result valid.
REQ-005 SHALL have port in_ready, output, 1: stage can accept a result.
REQ-006 SHALL have port in_sum, input, N: adder sum.
REQ-007 SHALL have port in_cout, input, 1: adder carry-out.
REQ-008 SHALL have port in_a_msb and in_b_msb, input, 1 each: operand sign bits, used for overflow detection.
REQ-009 SHALL have port out_valid, output, 1: head entry valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts.
REQ-011 SHALL have port out_sum, output, N, plus out_cout, output, 1: head entry result.
REQ-012 SHALL have ports out_zero, out_neg and out_ovf, output, 1 each: head entry flags.
REQ-013 SHALL have port result_count, output, 16: number of completed output handshakes.

Function
REQ-014 SHALL hold a 2-entry in-order FIFO (skid buffer) of {sum, cout, zero, neg, ovf}.
REQ-015 SHALL accept an entry on a rising edge with in_valid && in_ready, and SHALL pop one on out_valid && out_ready.
REQ-016 SHALL drive in_ready from a register: 1 when occupancy < 2, else 0; in_ready never depends combinationally on out_ready.
REQ-017 SHALL drive out_valid = (occupancy != 0) and present the oldest entry on out_*; latency is one cycle from accept to out_valid.
REQ-018 SHALL compute flags at capture: zero = (in_sum == 0), neg = in_sum[N-1], ovf = (in_a_msb == in_b_msb) && (in_sum[N-1] != in_a_msb).
REQ-019 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy at 1 and present the new entry next cycle.
REQ-020 SHALL ignore in_valid when in_ready = 0; upstream holds its data.
REQ-021 SHALL hold out_* stable while out_valid && !out_ready.
REQ-022 SHALL, on out_valid && !out_ready with occupancy 0, never occur; with occupancy 0, out_* values are don't-care but SHALL be the last-popped or reset values with no X.
REQ-023 SHALL increment result_count on each output handshake, wrapping 0xFFFF -> 0x0000.

Reset
REQ-024 SHALL, when rst_n = 0 at a rising edge, clear occupancy to 0, set in_ready = 1 and out_valid = 0, set out_sum = 0 and all out_* flags to 0, and set result_count = 0.
REQ-025 SHALL discard entries held when reset asserts mid-operation, and SHALL not accept a handshake in the reset cycle.
REQ-026 SHALL accept input on the first edge after rst_n returns to 1.

Configuration
REQ-027 SHALL, with macro ADDER_RESULT_STICKY_EN defined, add input sticky_clr (1) and output sticky_ovf (1).
REQ-028 With ADDER_RESULT_STICKY_EN defined, sticky_ovf SHALL set on any output handshake of an entry with ovf = 1, and SHALL clear on sticky_clr = 1 or on reset.
REQ-029 With ADDER_RESULT_STICKY_EN defined, when a set and sticky_clr coincide, the set wins.
REQ-030 SHALL, without ADDER_RESULT_STICKY_EN, omit those ports and that register; all other behaviour is identical.

Verification
REQ-031 SHALL cover single transfer: in_sum = 0x0000_0005, a_msb = b_msb = 0, out_ready = 1 -> next cycle out_valid = 1, out_sum = 5, zero = neg = ovf = 0, then result_count = 1.
REQ-032 SHALL cover overflow: in_sum = 0x8000_0000, a_msb = b_msb = 0 -> neg = 1, ovf = 1; with in_sum = 0, cout = 1 -> zero = 1, out_cout = 1.
REQ-033 SHALL cover backpressure: out_ready = 0, push 0x11 then 0x22 -> in_ready = 0; raising out_ready yields 0x11 then 0x22 in order with no loss.
REQ-034 SHALL cover streaming: in_valid = out_ready = 1 for 100 cycles with incrementing sums -> one output per cycle, in order, result_count = 100.
REQ-035 SHALL cover mid-operation reset: rst_n = 0 with 2 entries held -> next cycle out_valid = 0, in_ready = 1, result_count = 0.
REQ-036 SHALL cover the sticky flag with ADDER_RESULT_STICKY_EN: pop an ovf entry -> sticky_ovf = 1 and stays 1 across non-ovf pops; sticky_clr pulse -> 0.

Source files
------------

// File: rtl/adder_result_stage.sv
// Two-entry in-order result skid FIFO with zero/neg/ovf flags; one-cycle accept-to-valid latency,
// in_ready is registered and drops only when both entries are full. ADDER_RESULT_STICKY_EN adds sticky_ovf.
module adder_result_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_sum,
   input  logic         in_cout,
   input  logic         in_a_msb,
   input  logic         in_b_msb,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_cout,
   output logic         out_zero,
   output logic         out_neg,
   output logic         out_ovf,
`ifdef ADDER_RESULT_STICKY_EN
   input  logic         sticky_clr,
   output logic         sticky_ovf,
`endif
   output logic [15:0]  result_count
);

   typedef struct packed {
      logic [N-1:0] sum;
      logic         cout;
      logic         zero;
      logic         neg;
      logic         ovf;
   } entry_t;

   entry_t      head_q;
   entry_t      tail_q;
   entry_t      in_ent;
   logic [1:0]  count_q;
   logic [1:0]  count_d;
   logic        ready_q;
   logic [15:0] rcount_q;
   logic        push;
   logic        pop;

   always_comb begin
      in_ent      = '0;
      in_ent.sum  = in_sum;
      in_ent.cout = in_cout;
      in_ent.zero = (in_sum == '0);
      in_ent.neg  = in_sum[N-1];
      in_ent.ovf  = (in_a_msb == in_b_msb) && (in_sum[N-1] != in_a_msb);
   end

   assign push = in_valid && ready_q;
   assign pop  = (count_q != 2'd0) && out_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Head always holds the oldest entry; when the FIFO empties it keeps the last-popped value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         ready_q  <= 1'b1;
         head_q   <= '0;
         tail_q   <= '0;
         rcount_q <= 16'd0;
      end else begin
         count_q <= count_d;
         ready_q <= (count_d != 2'd2);
         if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
            head_q <= in_ent;
         end else if (pop && (count_q == 2'd2)) begin
            head_q <= tail_q;
         end
         if (push && (count_q == 2'd1) && !pop) begin
            tail_q <= in_ent;
         end
         if (pop) begin
            rcount_q <= rcount_q + 16'd1;
         end
      end
   end

`ifdef ADDER_RESULT_STICKY_EN
   logic sticky_q;

   // A popped overflow entry takes priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else if (pop && head_q.ovf) begin
         sticky_q <= 1'b1;
      end else if (sticky_clr) begin
         sticky_q <= 1'b0;
      end
   end

   assign sticky_ovf = sticky_q;
`endif

   assign in_ready     = ready_q;
   assign out_valid    = (count_q != 2'd0);
   assign out_sum      = head_q.sum;
   assign out_cout     = head_q.cout;
   assign out_zero     = head_q.zero;
   assign out_neg      = head_q.neg;
   assign out_ovf      = head_q.ovf;
   assign result_count = rcount_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage; sticky checks build only with ADDER_RESULT_STICKY_EN.
module tb_adder_result_stage;

   localparam int N = 32;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_sum;
   logic         in_cout;
   logic         in_a_msb;
   logic         in_b_msb;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_cout;
   logic         out_zero;
   logic         out_neg;
   logic         out_ovf;
   logic [15:0]  result_count;
`ifdef ADDER_RESULT_STICKY_EN
   logic         sticky_clr;
   logic         sticky_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   adder_result_stage #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sum       (in_sum),
      .in_cout      (in_cout),
      .in_a_msb     (in_a_msb),
      .in_b_msb     (in_b_msb),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_cout     (out_cout),
      .out_zero     (out_zero),
      .out_neg      (out_neg),
      .out_ovf      (out_ovf),
`ifdef ADDER_RESULT_STICKY_EN
      .sticky_clr   (sticky_clr),
      .sticky_ovf   (sticky_ovf),
`endif
      .result_count (result_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [N-1:0] s, input logic c, input logic a, input logic b);
      in_valid = v;
      in_sum   = s;
      in_cout  = c;
      in_a_msb = a;
      in_b_msb = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef ADDER_RESULT_STICKY_EN
      sticky_clr = 1'b0;
`endif
      do_reset();
      check("rst_in_ready",  64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum",   64'(out_sum), 64'd0);
      check("rst_flags",     64'({out_cout, out_zero, out_neg, out_ovf}), 64'd0);
      check("rst_count",     64'(result_count), 64'd0);

      // Single transfer, accepted on the first edge after reset release
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
      tick();
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_sum",   64'(out_sum), 64'd5);
      check("single_flags", 64'({out_cout, out_zero, out_neg, out_ovf}), 64'd0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      check("single_count", 64'(result_count), 64'd1);
      check("single_empty", 64'(out_valid), 64'd0);

      // Overflow, then a zero/carry entry pushed while the first pops
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      tick();
      check("ovf_sum",   64'(out_sum), 64'h8000_0000);
      check("ovf_flags", 64'({out_cout, out_zero, out_neg, out_ovf}), 64'b0011);
      drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      tick();
      check("zero_valid", 64'(out_valid), 64'd1);
      check("zero_sum",   64'(out_sum), 64'd0);
      check("zero_flags", 64'({out_cout, out_zero, out_neg, out_ovf}), 64'b1100);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      check("ovf_count", 64'(result_count), 64'd3);

      // Backpressure: fill both entries, then a held third input must be ignored
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_ready1", 64'(in_ready), 64'd1);
      check("bp_head1",  64'(out_sum), 64'h11);
      drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_full",  64'(in_ready), 64'd0);
      check("bp_head2", 64'(out_sum), 64'h11);
      drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_hold_sum",   64'(out_sum), 64'h11);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      check("bp_pop1_sum",   64'(out_sum), 64'h22);
      check("bp_pop1_ready", 64'(in_ready), 64'd1);
      tick();
      check("bp_pop2_valid", 64'(out_valid), 64'd0);
      check("bp_last_sum",   64'(out_sum), 64'h22);
      check("bp_count",      64'(result_count), 64'd5);

      // Streaming: one output per cycle for 100 cycles
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, N'(32'h1000 + i), 1'b0, 1'b0, 1'b0);
         tick();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_sum",   64'(out_sum), 64'(32'h1000 + i));
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      check("stream_count", 64'(result_count), 64'd100);
      check("stream_empty", 64'(out_valid), 64'd0);

      // Mid-operation reset with two entries held and input still offered
      out_ready = 1'b0;
      drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      tick();
      check("mid_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      tick();
      check("mid_valid", 64'(out_valid), 64'd0);
      check("mid_ready", 64'(in_ready), 64'd1);
      check("mid_count", 64'(result_count), 64'd0);
      check("mid_sum",   64'(out_sum), 64'd0);
      rst_n = 1'b1;
      drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      tick();
      check("post_rst_valid", 64'(out_valid), 64'd1);
      check("post_rst_sum",   64'(out_sum), 64'h77);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

`ifdef ADDER_RESULT_STICKY_EN
      do_reset();
      check("sticky_rst", 64'(sticky_ovf), 64'd0);
      out_ready = 1'b1;
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      tick();
      check("sticky_pre", 64'(sticky_ovf), 64'd0);
      drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
      tick();
      check("sticky_set", 64'(sticky_ovf), 64'd1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      check("sticky_hold", 64'(sticky_ovf), 64'd1);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_clr", 64'(sticky_ovf), 64'd0);
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_set_wins", 64'(sticky_ovf), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
